// File: rtl/burst_ram_pkg.sv
// Shared types and width helpers for the burst RAM.
package burst_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_be.sv
// Word-addressed storage: synchronous byte-enable write, asynchronous read.
module bram_be #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/burst_ram.sv
// Burst memory for cache refills and write-backs: fixed-length bursts over
// valid/ready channels with configurable read latency.
//
// state    | meaning
// ST_IDLE  | ready for a new burst request
// ST_WDATA | accepting write beats until the last one
// ST_RWAIT | counting down read latency
// ST_RDATA | presenting read beats until the last one is taken
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rlast,
  output logic                    wdone
);

  localparam int BW = clog2_min1(BURST_LEN);
  localparam int WW = clog2_min1(LATENCY);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [WW-1:0]         WAIT_INIT = WW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wdone_q, wdone_d;

  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign last_beat = (beat_q == LAST_BEAT);
  assign mem_addr  = base_q + ADDR_WIDTH'(beat_q);
  // Gated by rst so a beat coinciding with reset never lands in memory.
  assign mem_we    = (state_q == ST_WDATA) && wvalid && !rst;

  bram_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_addr),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .raddr_i (mem_addr),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      base_q  <= '0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      base_q  <= base_d;
      wdone_q <= wdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    base_d  = base_q;
    wdone_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d = req_addr & ~OFF_MASK;
          beat_d = '0;
          if (req_we) begin
            state_d = ST_WDATA;
          end else if (LATENCY == 1) begin
            state_d = ST_RDATA;
          end else begin
            state_d = ST_RWAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      ST_WDATA: begin
        if (wvalid) begin
          beat_d = beat_q + BW'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            wdone_d = 1'b1;
          end
        end
      end
      ST_RWAIT: begin
        if (wait_q == '0) state_d = ST_RDATA;
        else              wait_d  = wait_q - WW'(1);
      end
      ST_RDATA: begin
        if (rready) begin
          beat_d = beat_q + BW'(1);
          if (last_beat) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) && !rst;
    wready    = (state_q == ST_WDATA);
    rvalid    = (state_q == ST_RDATA);
    rdata     = rvalid ? mem_rdata : '0;
    rlast     = rvalid && last_beat;
    wdone     = wdone_q;
  end

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench: main instance (BURST_LEN=4, LATENCY=3) and a
// single-beat instance (BURST_LEN=1, LATENCY=1).
module tb_burst_ram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [11:0] a_req_addr;
  logic        a_wvalid, a_wready;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_rvalid, a_rready, a_rlast, a_wdone;
  logic [31:0] a_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [11:0] b_req_addr;
  logic        b_wvalid, b_wready;
  logic [31:0] b_wdata;
  logic [3:0]  b_wstrb;
  logic        b_rvalid, b_rready, b_rlast, b_wdone;
  logic [31:0] b_rdata;

  int n_cmp = 0;
  int n_err = 0;

  burst_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BURST_LEN(4), .LATENCY(3)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we), .req_addr(a_req_addr),
    .wvalid(a_wvalid), .wready(a_wready), .wdata(a_wdata), .wstrb(a_wstrb),
    .rvalid(a_rvalid), .rready(a_rready), .rdata(a_rdata), .rlast(a_rlast), .wdone(a_wdone)
  );

  burst_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BURST_LEN(1), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_addr(b_req_addr),
    .wvalid(b_wvalid), .wready(b_wready), .wdata(b_wdata), .wstrb(b_wstrb),
    .rvalid(b_rvalid), .rready(b_rready), .rdata(b_rdata), .rlast(b_rlast), .wdone(b_wdone)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Beat i uses d[i*32+:32] and s[i*4+:4]; gaps[i] inserts an idle cycle before beat i.
  task automatic write_a(input logic [11:0] addr, input logic [127:0] d, input logic [15:0] s,
                         input logic [3:0] gaps, input int nbeats);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = addr;
    chk("w_req_ready", {63'd0, a_req_ready}, 64'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps[i]) begin
        a_wvalid = 1'b0;
        @(negedge clk);
        chk("w_gap_wready", {63'd0, a_wready}, 64'd1);
      end
      a_wvalid = 1'b1; a_wdata = d[i*32 +: 32]; a_wstrb = s[i*4 +: 4];
      chk("w_wready", {63'd0, a_wready}, 64'd1);
      @(negedge clk);
    end
    a_wvalid = 1'b0;
    if (nbeats == 4) begin
      chk("w_wdone", {63'd0, a_wdone}, 64'd1);
      chk("w_ready_back", {63'd0, a_req_ready}, 64'd1);
    end
  endtask

  // pat[c] is the rready value driven in the c-th cycle of the data phase.
  task automatic read_a(input logic [11:0] addr, input logic [127:0] e, input logic [7:0] pat,
                        input int exp_lat);
    int cyc;
    int k;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = addr;
    chk("r_req_ready", {63'd0, a_req_ready}, 64'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    cyc = 1;
    while (!a_rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("r_latency", 64'(cyc), 64'(exp_lat));
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      a_rready = pat[cyc % 8];
      chk("r_rvalid", {63'd0, a_rvalid}, 64'd1);
      chk("r_rdata", {32'd0, a_rdata}, {32'd0, e[k*32 +: 32]});
      chk("r_rlast", {63'd0, a_rlast}, (k == 3) ? 64'd1 : 64'd0);
      @(negedge clk);
      if (a_rready) k++;
      cyc++;
    end
    a_rready = 1'b0;
    chk("r_beats", 64'(k), 64'd4);
    chk("r_end_rvalid", {63'd0, a_rvalid}, 64'd0);
    chk("r_end_rdata", {32'd0, a_rdata}, 64'd0);
    chk("r_end_ready", {63'd0, a_req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_wvalid = 0; a_wdata = '0; a_wstrb = '0; a_rready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_wvalid = 0; b_wdata = '0; b_wstrb = '0; b_rready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'd0, a_req_ready}, 64'd0);
    chk("rst_wready", {63'd0, a_wready}, 64'd0);
    chk("rst_rvalid", {63'd0, a_rvalid}, 64'd0);
    chk("rst_rdata", {32'd0, a_rdata}, 64'd0);
    chk("rst_rlast", {63'd0, a_rlast}, 64'd0);
    chk("rst_wdone", {63'd0, a_wdone}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, a_req_ready}, 64'd1);

    // Unaligned write base 0x013 -> 0x010, then immediate read-after-write.
    write_a(12'h013, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF, 4'b0000, 4);
    read_a(12'h010, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hFF, 3);

    // Backpressure: rready 1,0,0,1,0,1,1,0 repeating.
    read_a(12'h012, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'b0110_1001, 3);

    // Byte strobes over a known background.
    write_a(12'h020, {4{32'h11223344}}, 16'hFFFF, 4'b0000, 4);
    @(negedge clk);
    chk("wdone_one_cycle", {63'd0, a_wdone}, 64'd0);
    write_a(12'h020, {4{32'hAABBCCDD}}, 16'hAF05, 4'b0000, 4);
    read_a(12'h020, {32'hAA22CC44, 32'hAABBCCDD, 32'h11223344, 32'h11BB33DD}, 8'hFF, 3);

    // Gapped write beats.
    write_a(12'h031, {32'h33, 32'h32, 32'h31, 32'h30}, 16'hFFFF, 4'b1011, 4);
    read_a(12'h030, {32'h33, 32'h32, 32'h31, 32'h30}, 8'hFF, 3);

    // Reset after two of four beats.
    write_a(12'h040, {32'h43, 32'h42, 32'h41, 32'h40}, 16'hFFFF, 4'b0000, 4);
    write_a(12'h040, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'hFFFF, 4'b0000, 2);
    rst = 1'b1;
    chk("abort_ready_in_rst", {63'd0, a_req_ready}, 64'd0);
    @(negedge clk);
    chk("abort_ready_in_rst2", {63'd0, a_req_ready}, 64'd0);
    chk("abort_wdone", {63'd0, a_wdone}, 64'd0);
    chk("abort_wready", {63'd0, a_wready}, 64'd0);
    rst = 1'b0;
    // A stray write beat while idle must be ignored.
    a_wvalid = 1'b1; a_wdata = 32'hDEADBEEF; a_wstrb = 4'hF;
    chk("idle_wready", {63'd0, a_wready}, 64'd0);
    @(negedge clk);
    a_wvalid = 1'b0;
    chk("abort_ready_back", {63'd0, a_req_ready}, 64'd1);
    chk("abort_no_wdone", {63'd0, a_wdone}, 64'd0);
    read_a(12'h040, {32'h43, 32'h42, 32'hC1, 32'hC0}, 8'hFF, 3);

    // Single-beat, single-cycle-latency instance at the top address.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 12'hFFF;
    chk("b_w_req_ready", {63'd0, b_req_ready}, 64'd1);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("b_wready", {63'd0, b_wready}, 64'd1);
    b_wvalid = 1'b1; b_wdata = 32'h5A5A0FF0; b_wstrb = 4'hF;
    @(negedge clk);
    b_wvalid = 1'b0;
    chk("b_wdone", {63'd0, b_wdone}, 64'd1);
    chk("b_wready_off", {63'd0, b_wready}, 64'd0);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 12'hFFF;
    chk("b_r_req_ready", {63'd0, b_req_ready}, 64'd1);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("b_rvalid", {63'd0, b_rvalid}, 64'd1);
    chk("b_rlast", {63'd0, b_rlast}, 64'd1);
    chk("b_rdata", {32'd0, b_rdata}, 64'h5A5A0FF0);
    b_rready = 1'b1;
    @(negedge clk);
    b_rready = 1'b0;
    chk("b_end_rvalid", {63'd0, b_rvalid}, 64'd0);
    chk("b_end_ready", {63'd0, b_req_ready}, 64'd1);
    chk("b_end_wdone", {63'd0, b_wdone}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
